// File: rtl/dmg_timer_ctrl.sv
// rtl/dmg_timer_ctrl.sv - DMG timer block: DIV/TIMA/TMA/TAC registers, tap edge detect, overflow reload and IRQ.
module dmg_timer_ctrl #(
  parameter int DIV_W  = 14,
  parameter int TAP_00 = 7,
  parameter int TAP_01 = 1,
  parameter int TAP_10 = 3,
  parameter int TAP_11 = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic [1:0]       addr,
  input  logic             cpu_wr,
  input  logic             cpu_rd,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  input  logic [DIV_W-1:0] div,
  output logic             div_clr,
  output logic             irq_timer
);

  localparam int IW = $clog2(DIV_W);

  typedef enum logic [1:0] {RUN, OVF, RELOAD} state_t;

  state_t     state_q, state_d;
  logic [7:0] tima_q, tima_d;
  logic [7:0] tma_q, tma_d;
  logic [2:0] tac_q, tac_d;
  logic       prev_sig_q;
  logic       irq_q, irq_d;

  logic [IW-1:0] tap_idx;
  logic          sig, inc;
  logic          wr_en, tima_wr, tma_wr, tac_wr;

  assign wr_en   = sel & cpu_wr;
  assign tima_wr = wr_en & (addr == 2'd1);
  assign tma_wr  = wr_en & (addr == 2'd2);
  assign tac_wr  = wr_en & (addr == 2'd3);
  assign div_clr = wr_en & (addr == 2'd0);

  always_comb begin
    tap_idx = IW'(TAP_00);
    case (tac_q[1:0])
      2'b00: tap_idx = IW'(TAP_00);
      2'b01: tap_idx = IW'(TAP_01);
      2'b10: tap_idx = IW'(TAP_10);
      2'b11: tap_idx = IW'(TAP_11);
      default: tap_idx = IW'(TAP_00);
    endcase
  end

  // Every increment, including the DIV-write and TAC-write glitches, is just a falling edge of sig.
  assign sig = tac_q[2] & div[tap_idx];
  assign inc = prev_sig_q & ~sig;

  always_comb begin
    rdata = 8'h00;
    if (sel && cpu_rd) begin
      case (addr)
        2'd0: rdata = div[DIV_W-1 -: 8];
        2'd1: rdata = tima_q;
        2'd2: rdata = tma_q;
        2'd3: rdata = {5'b11111, tac_q};
        default: rdata = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    tima_d  = tima_q;
    tma_d   = tma_wr ? wdata : tma_q;
    tac_d   = tac_wr ? wdata[2:0] : tac_q;
    irq_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (tima_wr) begin
          tima_d = wdata;
        end else if (inc) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = OVF;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      OVF: begin
        if (tima_wr) begin
          tima_d  = wdata;
          state_d = RUN;
        end else begin
          tima_d  = tma_wr ? wdata : tma_q;
          irq_d   = 1'b1;
          state_d = RELOAD;
        end
      end
      RELOAD: begin
        // TIMA tracks TMA writes here; direct TIMA writes lose to the reload.
        if (tma_wr) tima_d = wdata;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      tima_q     <= 8'h00;
      tma_q      <= 8'h00;
      tac_q      <= 3'b000;
      prev_sig_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tima_q     <= tima_d;
      tma_q      <= tma_d;
      tac_q      <= tac_d;
      prev_sig_q <= sig;
      irq_q      <= irq_d;
    end
  end

  assign irq_timer = irq_q;

endmodule

// File: tb/tb_dmg_timer_ctrl.sv
// tb/tb_dmg_timer_ctrl.sv - directed scoreboard bench for dmg_timer_ctrl.
module tb_dmg_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [1:0]  addr;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [13:0] div;
  logic        div_clr;
  logic        irq_timer;

  logic        div_run;
  logic [7:0]  v;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  dmg_timer_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .addr      (addr),
    .cpu_wr    (cpu_wr),
    .cpu_rd    (cpu_rd),
    .wdata     (wdata),
    .rdata     (rdata),
    .div       (div),
    .div_clr   (div_clr),
    .irq_timer (irq_timer)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // One clock: the divider model clears when div_clr was high at the edge.
  task automatic tick();
    logic cl;
    cl = div_clr;
    @(posedge clk);
    #1;
    if (cl) div = 14'd0;
    else if (div_run) div = div + 14'd1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    sel = 1'b1; cpu_wr = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; cpu_wr = 1'b0; wdata = 8'h00;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    sel = 1'b1; cpu_rd = 1'b1; addr = a;
    #1;
    d = rdata;
    sel = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic irq_check(input string tag, input logic exp);
    push(tag, {7'd0, exp});
    pop_check({7'd0, irq_timer});
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; addr = 2'd0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    wdata = 8'h00; div = 14'd0; div_run = 1'b0;
    tick(); tick();
    reset = 1'b0;

    push("rst_div", 8'h00);  rd(2'd0, v); pop_check(v);
    push("rst_tima", 8'h00); rd(2'd1, v); pop_check(v);
    push("rst_tma", 8'h00);  rd(2'd2, v); pop_check(v);
    push("rst_tac", 8'hF8);  rd(2'd3, v); pop_check(v);
    irq_check("rst_irq", 1'b0);
    push("rst_divclr", 8'h00); pop_check({7'd0, div_clr});

    // Counting at tap bit 1: one increment per 4 cycles.
    div = 14'd0; div_run = 1'b1;
    wr(2'd3, 8'h05);
    push("cnt_20", 8'h05);
    repeat (20) tick();
    rd(2'd1, v); pop_check(v);
    push("cnt_40", 8'h0A);
    repeat (20) tick();
    rd(2'd1, v); pop_check(v);
    div_run = 1'b0;
    div = 14'h1AC0;
    push("div_read", 8'h6B); rd(2'd0, v); pop_check(v);

    // Plain overflow and reload.
    div = 14'd2;
    wr(2'd2, 8'hF0);
    wr(2'd1, 8'hFF);
    div = 14'd4;
    tick();
    push("ovf_tima", 8'h00); rd(2'd1, v); pop_check(v);
    irq_check("ovf_irq", 1'b0);
    tick();
    push("rld_tima", 8'hF0); rd(2'd1, v); pop_check(v);
    irq_check("rld_irq", 1'b1);
    tick();
    irq_check("post_irq", 1'b0);
    push("post_tima", 8'hF0); rd(2'd1, v); pop_check(v);

    // TIMA write during OVF cancels reload and IRQ.
    div = 14'd2;
    wr(2'd1, 8'hFF);
    div = 14'd4;
    tick();
    wr(2'd1, 8'h33);
    push("ovfwr_tima", 8'h33); rd(2'd1, v); pop_check(v);
    irq_check("ovfwr_irq", 1'b0);
    tick();
    irq_check("ovfwr_irq2", 1'b0);
    push("ovfwr_tima2", 8'h33); rd(2'd1, v); pop_check(v);

    // TIMA write during RELOAD is ignored.
    div = 14'd2;
    wr(2'd1, 8'hFF);
    div = 14'd4;
    tick(); tick();
    irq_check("rldwr_irq", 1'b1);
    wr(2'd1, 8'h33);
    push("rldwr_tima", 8'hF0); rd(2'd1, v); pop_check(v);
    irq_check("rldwr_irq2", 1'b0);

    // TMA write during RELOAD lands in both TMA and TIMA.
    div = 14'd2;
    wr(2'd1, 8'hFF);
    div = 14'd4;
    tick(); tick();
    irq_check("rldtma_irq", 1'b1);
    wr(2'd2, 8'h77);
    push("rldtma_tima", 8'h77); rd(2'd1, v); pop_check(v);
    push("rldtma_tma", 8'h77);  rd(2'd2, v); pop_check(v);
    irq_check("rldtma_irq2", 1'b0);
    tick();
    irq_check("rldtma_irq3", 1'b0);

    // DIV write with tap high gives a glitch increment.
    div = 14'd2;
    wr(2'd1, 8'h10);
    tick();
    sel = 1'b1; cpu_wr = 1'b1; addr = 2'd0; wdata = 8'h00;
    #1;
    push("divclr_hi", 8'h01); pop_check({7'd0, div_clr});
    tick();
    sel = 1'b0; cpu_wr = 1'b0;
    push("divwr_tima0", 8'h10); rd(2'd1, v); pop_check(v);
    tick();
    push("divwr_tima1", 8'h11); rd(2'd1, v); pop_check(v);
    push("divclr_lo", 8'h00); pop_check({7'd0, div_clr});
    wr(2'd0, 8'h00);
    tick();
    push("divwr_low", 8'h11); rd(2'd1, v); pop_check(v);

    // TAC disable while tap high gives a glitch increment.
    div = 14'd2;
    tick();
    wr(2'd3, 8'h01);
    push("tac_tima0", 8'h11); rd(2'd1, v); pop_check(v);
    tick();
    push("tac_tima1", 8'h12); rd(2'd1, v); pop_check(v);
    push("tac_read", 8'hF9);  rd(2'd3, v); pop_check(v);

    // Reset during OVF.
    wr(2'd3, 8'h05);
    wr(2'd1, 8'hFF);
    div = 14'd4;
    tick();
    push("rstovf_pre", 8'h00); rd(2'd1, v); pop_check(v);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push("rstovf_tima", 8'h00); rd(2'd1, v); pop_check(v);
    push("rstovf_tma", 8'h00);  rd(2'd2, v); pop_check(v);
    push("rstovf_tac", 8'hF8);  rd(2'd3, v); pop_check(v);
    irq_check("rstovf_irq", 1'b0);
    tick();
    irq_check("rstovf_irq2", 1'b0);
    push("rstovf_tima2", 8'h00); rd(2'd1, v); pop_check(v);

    // Unselected write ignored; select without read gives 00.
    sel = 1'b0; cpu_wr = 1'b1; addr = 2'd1; wdata = 8'h55;
    tick();
    cpu_wr = 1'b0;
    push("nosel_tima", 8'h00); rd(2'd1, v); pop_check(v);
    sel = 1'b1; cpu_rd = 1'b0; addr = 2'd3;
    #1;
    push("nord_rdata", 8'h00); pop_check(rdata);
    sel = 1'b0;

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
